// File: rtl/fp_add_pkg.sv
// Shared widths, operand classes, canonical NaN and flag positions for the
// pipelined floating-point adder.
package fp_add_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    localparam int FLG_W        = 3;
    localparam int FLG_INVALID  = 2;
    localparam int FLG_OVERFLOW = 1;
    localparam int FLG_INEXACT  = 0;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_cls_e;

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Quiet NaN: positive sign, all-ones exponent, only the fraction MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

endpackage

// File: rtl/fp_add_pipe_lzc.sv
// Parametrised leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
    parameter  int WIDTH = 28,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        cnt_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready flow.
// Define FP_ADD_PIPE_ROUND_EN for round-to-nearest-even; otherwise truncation.
module fp_add_pipe
    import fp_add_pkg::*;
#(
    parameter  int EXP_W = EXP_W_DEF,
    parameter  int MAN_W = MAN_W_DEF,
    localparam int W     = fp_width(EXP_W, MAN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_res,
    output logic [FLG_W-1:0] out_flags
);

    localparam int SW   = MAN_W + 4;
    localparam int NW   = MAN_W + 5;
    localparam int EW   = EXP_W + 2;
    localparam int LZ_W = $clog2(NW + 1);
    localparam logic [W-1:0]          QNAN     = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic signed [EW-1:0]  EXP_MAX  = EW'((1 << EXP_W) - 1);

    function automatic fp_cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0) return CLS_ZERO;
        if (e == EXP_ONES) return (f != '0) ? CLS_NAN : CLS_INF;
        return CLS_NORM;
    endfunction

`ifdef FP_ADD_PIPE_ROUND_EN
    function automatic logic rne_up(input logic lsb, input logic g, input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction
`endif

    logic adv;
    logic vld_p1_q, vld_p2_q, out_valid_q;
    logic [W-1:0]     out_res_q;
    logic [FLG_W-1:0] out_flags_q;

    assign adv       = out_ready | ~out_valid_q;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_flags = out_flags_q;

    // ---- stage 1: unpack, order by magnitude, align, classify ----
    logic                   sa, sb, sx, sy, swap;
    logic [EXP_W-1:0]       ea, eb, ex, ey, diff;
    logic [MAN_W-1:0]       fa, fb, fx, fy;
    logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
    fp_cls_e                ca, cb;
    logic [SW-1:0]          xsig, ysig_al;
    logic [2*SW-1:0]        ywide;
    int                     shamt;
    logic                   spec_d;
    logic [W-1:0]           sres_d;
    logic [FLG_W-1:0]       sflg_d;

    assign sa = in_a[W-1];
    assign ea = in_a[W-2:MAN_W];
    assign fa = in_a[MAN_W-1:0];
    assign sb = in_b[W-1] ^ in_sub;
    assign eb = in_b[W-2:MAN_W];
    assign fb = in_b[MAN_W-1:0];
    assign ca = classify(ea, fa);
    assign cb = classify(eb, fb);

    assign mag_a = (ca == CLS_ZERO) ? '0 : in_a[W-2:0];
    assign mag_b = (cb == CLS_ZERO) ? '0 : in_b[W-2:0];
    assign swap  = mag_b > mag_a;
    assign sx    = swap ? sb : sa;
    assign sy    = swap ? sa : sb;
    assign ex    = swap ? eb : ea;
    assign ey    = swap ? ea : eb;
    assign fx    = swap ? fb : fa;
    assign fy    = swap ? fa : fb;
    assign diff  = ex - ey;
    assign xsig  = {1'b1, fx, 3'b000};

    // The low half of ywide catches everything shifted past the sticky position.
    always_comb begin
        shamt   = (int'(diff) > SW) ? SW : int'(diff);
        ywide   = {1'b1, fy, 3'b000, {SW{1'b0}}} >> shamt;
        ysig_al = {ywide[2*SW-1:SW+1], ywide[SW] | (|ywide[SW-1:0])};
    end

    always_comb begin
        spec_d = 1'b1;
        sres_d = '0;
        sflg_d = '0;
        if (ca == CLS_NAN || cb == CLS_NAN) begin
            sres_d = QNAN;
        end else if (ca == CLS_INF && cb == CLS_INF) begin
            if (sa != sb) begin
                sres_d = QNAN;
                sflg_d[FLG_INVALID] = 1'b1;
            end else begin
                sres_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
            end
        end else if (ca == CLS_INF) begin
            sres_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (cb == CLS_INF) begin
            sres_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (ca == CLS_ZERO && cb == CLS_ZERO) begin
            sres_d = {sa & sb, {(W-1){1'b0}}};
        end else if (cb == CLS_ZERO) begin
            sres_d = in_a;
        end else if (ca == CLS_ZERO) begin
            sres_d = {sb, eb, fb};
        end else begin
            spec_d = 1'b0;
        end
    end

    logic             sx_p1_q, sy_p1_q, spec_p1_q;
    logic [EXP_W-1:0] ex_p1_q;
    logic [SW-1:0]    xsig_p1_q, ysig_p1_q;
    logic [W-1:0]     sres_p1_q;
    logic [FLG_W-1:0] sflg_p1_q;

    // ---- stage 2: add or subtract magnitudes ----
    logic [NW-1:0]    sum_d;
    logic             sx_p2_q, spec_p2_q;
    logic [EXP_W-1:0] ex_p2_q;
    logic [NW-1:0]    sum_p2_q;
    logic [W-1:0]     sres_p2_q;
    logic [FLG_W-1:0] sflg_p2_q;

    assign sum_d = (sx_p1_q ^ sy_p1_q) ? ({1'b0, xsig_p1_q} - {1'b0, ysig_p1_q})
                                       : ({1'b0, xsig_p1_q} + {1'b0, ysig_p1_q});

    always_ff @(posedge clk) begin
        if (adv) begin
            sx_p1_q   <= sx;
            sy_p1_q   <= sy;
            ex_p1_q   <= ex;
            xsig_p1_q <= xsig;
            ysig_p1_q <= ysig_al;
            spec_p1_q <= spec_d;
            sres_p1_q <= sres_d;
            sflg_p1_q <= sflg_d;
            sx_p2_q   <= sx_p1_q;
            ex_p2_q   <= ex_p1_q;
            sum_p2_q  <= sum_d;
            spec_p2_q <= spec_p1_q;
            sres_p2_q <= sres_p1_q;
            sflg_p2_q <= sflg_p1_q;
        end
    end

    // ---- stage 3: normalise, round, pack ----
    logic [LZ_W-1:0]        lz;
    logic [NW-2:0]          nrm;
    logic signed [EW-1:0]   exp_x, exp_n, exp_r;
    logic [MAN_W-1:0]       frac;
    logic                   inexact;
    logic [W-1:0]           res_d;
    logic [FLG_W-1:0]       flg_d;
`ifdef FP_ADD_PIPE_ROUND_EN
    logic [MAN_W:0]         frac_inc;
`endif

    fp_lzc #(.WIDTH(NW)) u_lzc (
        .data_i (sum_p2_q),
        .cnt_o  (lz)
    );

    assign exp_x = signed'({2'b00, ex_p2_q});

    // nrm keeps the hidden bit at its top; a clear hidden bit means an exact zero.
    always_comb begin
        nrm   = '0;
        exp_n = exp_x;
        if (sum_p2_q[NW-1]) begin
            nrm   = {sum_p2_q[NW-1:2], sum_p2_q[1] | sum_p2_q[0]};
            exp_n = exp_x + EW'(1);
        end else begin
            nrm   = sum_p2_q[NW-2:0] << (lz - LZ_W'(1));
            exp_n = exp_x - EW'(lz) + EW'(1);
        end
        inexact = |nrm[2:0];
`ifdef FP_ADD_PIPE_ROUND_EN
        frac_inc = {1'b0, nrm[NW-3:3]} + (MAN_W+1)'(rne_up(nrm[3], nrm[2], nrm[1], nrm[0]));
        frac     = frac_inc[MAN_W-1:0];
        exp_r    = frac_inc[MAN_W] ? exp_n + EW'(1) : exp_n;
`else
        frac     = nrm[NW-3:3];
        exp_r    = exp_n;
`endif
        res_d = {sx_p2_q, exp_r[EXP_W-1:0], frac};
        flg_d = '0;
        flg_d[FLG_INEXACT] = inexact;
        if (spec_p2_q) begin
            res_d = sres_p2_q;
            flg_d = sflg_p2_q;
        end else if (!nrm[NW-2]) begin
            res_d = '0;
            flg_d = '0;
        end else if (exp_n <= 0) begin
            res_d = {sx_p2_q, {(W-1){1'b0}}};
            flg_d = '0;
            flg_d[FLG_INEXACT] = 1'b1;
        end else if (exp_r >= EXP_MAX) begin
            res_d = {sx_p2_q, EXP_ONES, {MAN_W{1'b0}}};
            flg_d[FLG_OVERFLOW] = 1'b1;
            flg_d[FLG_INEXACT]  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_flags_q <= '0;
        end else if (adv) begin
            vld_p1_q    <= in_valid;
            vld_p2_q    <= vld_p1_q;
            out_valid_q <= vld_p2_q;
            out_res_q   <= res_d;
            out_flags_q <= flg_d;
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed self-checking bench for fp_add_pipe (default single-precision widths).
module tb_fp_add_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [2:0]  out_flags;

    int errors = 0;
    int checks = 0;

    fp_add_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated pair: checks acceptance, exact 3-edge latency, result and flags.
    task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] er, input logic [2:0] ef);
        @(negedge clk);
        out_ready = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_valid  = 1'b1;
        #1 chk({tag, "_rdy"}, 64'(in_ready), 64'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({tag, "_lat1"}, 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        #1 chk({tag, "_lat2"}, 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        #1;
        chk({tag, "_vld"}, 64'(out_valid), 64'(1'b1));
        chk({tag, "_res"}, 64'(out_res), 64'(er));
        chk({tag, "_flg"}, 64'(out_flags), 64'(ef));
    endtask

    logic [31:0] bp_a [6];
    logic [31:0] bp_e [6];
    int sent, rcv, stall_left;
    logic seen;
    logic [31:0] rnd_exp;

    initial begin
        bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        bp_e = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};
`ifdef FP_ADD_PIPE_ROUND_EN
        rnd_exp = 32'h3F800001;
`else
        rnd_exp = 32'h3F800000;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_valid", 64'(out_valid), 64'(1'b0));
        chk("reset_res", 64'(out_res), 64'(32'h0));
        chk("reset_flags", 64'(out_flags), 64'(3'b000));
        chk("reset_in_ready", 64'(in_ready), 64'(1'b1));
        @(negedge clk);
        rst = 1'b0;

        run1("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        run1("three_minus_one", 32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 3'b000);
        run1("sub_three_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
        run1("exact_cancel", 32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 3'b000);
        run1("one_minus_two", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
        run1("inf_plus_fin", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
        run1("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        run1("nan_in", 32'hFF812345, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
        run1("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        run1("round_up", 32'h3F800000, 32'h33C00000, 1'b0, rnd_exp, 3'b001);
        run1("round_tie", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        run1("x_plus_negzero", 32'h40490FDB, 32'h80000000, 1'b0, 32'h40490FDB, 3'b000);
        run1("negzero_sum", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        run1("zero_minus_zero", 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000);
        run1("subnormal_flush", 32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
        run1("underflow", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);

        // Back-pressure: six back-to-back pairs, consumer stalls 5 cycles at first result.
        @(negedge clk);
        sent = 0;
        rcv = 0;
        stall_left = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1;
                stall_left = 5;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            #1;
            if (out_valid && !out_ready) begin
                chk("bp_in_ready", 64'(in_ready), 64'(1'b0));
                chk("bp_hold", 64'(out_res), 64'(bp_e[rcv]));
            end
            if (out_valid && out_ready) begin
                chk("bp_res", 64'(out_res), 64'(bp_e[rcv]));
                rcv++;
            end
            in_valid = (sent < 6);
            if (sent < 6) begin
                in_a   = bp_a[sent];
                in_b   = bp_a[sent];
                in_sub = 1'b0;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        chk("bp_received", 64'(rcv), 64'(6));
        chk("bp_sent", 64'(sent), 64'(6));
        @(negedge clk);
        #1 chk("bp_drain", 64'(out_valid), 64'(1'b0));

        // Reset with pairs in flight.
        @(negedge clk);
        out_ready = 1'b1;
        in_a = 32'h3F800000;
        in_b = 32'h3F800000;
        in_sub = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_a = 32'h40000000;
        in_b = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 chk("rst_pre_valid", 64'(out_valid), 64'(1'b1));
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_async_res", 64'(out_res), 64'(32'h0));
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1 chk("rst_no_stale", 64'(out_valid), 64'(1'b0));
        end
        run1("post_rst", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Pipelined, parametrised IEEE-754-style floating-point adder/subtractor; next-generation replacement for the combinational single-precision adder in the XOR neural-net datapath.
- Three register stages with a valid/ready handshake, so neuron accumulators can stream operand pairs at one pair per clock.
- Handles zero, infinity and NaN.
- Subnormals are flushed to zero.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width, excluding the hidden bit.
- Derived: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_sub  in  1  1 = compute A-B; B sign is inverted at stage 1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_res  out  W  result.
- out_flags  out  3  {invalid, overflow, inexact}.

Behaviour:
- Reset: all stage valid bits, out_valid, out_res and out_flags = 0. Reset asserted mid-operation discards all in-flight pairs; nothing is emitted after release.
- Pipeline advance: adv = out_ready | ~out_valid. in_ready = adv (combinational).
  - When adv=1, all stages shift one place; stage-1 valid loads in_valid.
  - When adv=0, every stage holds.
- Transfers happen only on valid&ready. Latency is exactly 3 cycles from accept to out_valid when there is no stall. Throughput is 1 per clock. Order is preserved.
- Stage 1 (unpack/align):
  - Split sign, exponent and fraction.
  - Exponent 0 is treated as ±0; fraction is ignored (flush to zero).
  - Swap operands so |X| >= |Y|, comparing {exp,frac}.
  - Right-shift Y's significand {1,frac} by the exponent difference into a MAN_W+4 field {sig, guard, round, sticky}. Sticky ORs all bits shifted out. A difference > MAN_W+3 leaves sticky only.
  - Classify specials.
- Stage 2 (add):
  - Effective subtract = sX^sY.
  - Add or subtract in MAN_W+5 bits. The result is never negative because of the swap.
  - Result sign = sX.
- Stage 3 (normalise/round/pack):
  - On carry-out: shift right 1 (sticky absorbs the lost bit) and increment exponent.
  - Otherwise: leading-zero count, shift left, exponent -= lzc.
  - Exact zero result from a subtract → +0. Exception: (-0)+(-0) → -0.
  - Exponent underflow (<=0) → ±0, inexact=1.
  - Exponent >= 2^EXP_W-1 after rounding → ±inf, overflow=1, inexact=1.
  - inexact = guard|round|sticky before rounding.
- Specials:
  - NaN input → canonical quiet NaN {0, all-ones exp, 1, zeros}, invalid=0.
  - inf + (-inf) in effective-subtract → quiet NaN, invalid=1.
  - inf with finite → that inf.
  - x+0 → x, exact.
- Specials bypass the arithmetic but travel through all 3 stages to keep latency fixed.

Optional Feature:
- Macro FP_ADD_PIPE_ROUND_EN.
- Defined: round-to-nearest-even in stage 3 using guard/round/sticky and the LSB. Mantissa overflow on round re-normalises with exponent+1.
- Undefined: truncation toward zero; no increment logic; inexact is still reported.
- Latency is unchanged either way.

Decomposition:
- Package fp_add_pkg:
  - Field-width localparams, derived from the defaults and overridable via functions.
  - Special-class enum {ZERO, NORM, INF, NAN}.
  - Canonical-NaN constant.
  - Flag bit indices.
- One sub-module: fp_lzc (parametrised leading-zero counter, width MAN_W+5), instantiated in stage 3.

Test Plan:
1. 0x3F800000 + 0x3F800000 → 0x40000000 three cycles after accept; flags 0.
2. 0x40400000 + 0xBF800000 (3.0 + -1.0) → 0x40000000. Same values with in_sub=1 and B=0x3F800000 → 0x40000000. 0x3FC00000 - 0x3FC00000 → 0x00000000.
3. 0x7F800000 + 0x3F800000 → 0x7F800000. 0x7F800000 + 0xFF800000 → 0x7FC00000 with invalid=1. 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with overflow=1 and inexact=1.
4. Rounding, 0x3F800000 + 0x33C00000:
   - With FP_ADD_PIPE_ROUND_EN → 0x3F800001.
   - Without it → 0x3F800000.
   - Tie case 0x3F800000 + 0x33800000 → 0x3F800000 in both builds; inexact=1 in all three results.
5. Back-pressure: issue 6 back-to-back pairs, hold out_ready=0 for 5 cycles from the first out_valid.
   - in_ready=0 while out_valid=1 and out_ready=0.
   - Outputs hold stable.
   - All 6 results arrive in order with none lost or duplicated.
6. Assert rst for 1 cycle with 2 pairs in flight → out_valid=0 immediately. No stale result after release; the next accepted pair emerges after exactly 3 cycles.
